// File: rtl/conv_weight_load_ctrl.sv
// conv_weight_load_ctrl: streams 32-bit weight words from a source FIFO into a
// conv layer's weight port (kernel, then bias, then macc-coeff regions) and keeps
// the layer's activation path gated until the full load has been written.
// Optional build macro CONV_WEIGHT_LOAD_CHECKSUM_EN adds exp_sum/sum_err and
// withholds load_done when the wrapping sum of accepted words does not match.
module conv_weight_load_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'd0,
  parameter int unsigned NUM_KERNEL     = 72,
  parameter int unsigned NUM_BIAS       = 4,
  parameter int unsigned NUM_MACC_COEFF = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] weight_wr_data,
  output logic [31:0] weight_wr_addr,
  output logic        weight_wr_en,
  input  logic        act_valid_in,
  output logic        act_valid_out,
  input  logic        act_rd_en_in,
  output logic        act_rd_en_out,
  output logic        busy,
  output logic        load_done,
`ifdef CONV_WEIGHT_LOAD_CHECKSUM_EN
  input  logic [31:0] exp_sum,
  output logic        sum_err,
`endif
  output logic [1:0]  region
);

  localparam int unsigned TOTAL = NUM_KERNEL + NUM_BIAS + NUM_MACC_COEFF;
  localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] KernelEnd = CNT_W'(NUM_KERNEL);
  localparam logic [CNT_W-1:0] BiasEnd   = CNT_W'(NUM_KERNEL + NUM_BIAS);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en_q;
  logic [31:0]      wr_addr_q, wr_data_q;
  logic             load_done_q, load_done_d;
  logic             beat, start_ok, done_ok;

  // A beat colliding with abort is discarded: abort has priority.
  assign s_ready  = (state_q == StLoad);
  assign beat     = s_valid & s_ready & ~abort;
  assign start_ok = start & (state_q != StLoad);

`ifdef CONV_WEIGHT_LOAD_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        sum_err_q, sum_err_d;

  // Running checksum; the verdict is latched together with the last beat.
  always_comb begin
    sum_d     = sum_q;
    sum_err_d = sum_err_q;
    if (abort || start_ok) begin
      sum_d     = '0;
      sum_err_d = 1'b0;
    end else if (beat) begin
      sum_d = sum_q + s_data;
      if (cnt_q == LastCnt) sum_err_d = ((sum_q + s_data) != exp_sum);
    end
  end

  // Checksum registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      sum_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      sum_err_q <= sum_err_d;
    end
  end

  assign sum_err = sum_err_q;
  assign done_ok = ~sum_err_q;
`else
  assign done_ok = 1'b1;
`endif

  // Next-state and word counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StLoad;
            cnt_d   = '0;
          end
        end
        StLoad: begin
          if (beat) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LastCnt) state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // load_done rises once the final write pulse (seen as wr_en in DONE) is out
  always_comb begin
    load_done_d = load_done_q;
    if (abort || start_ok) begin
      load_done_d = 1'b0;
    end else if ((state_q == StDone) && wr_en_q) begin
      load_done_d = done_ok;
    end
  end

  // State, counter and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_done_q <= load_done_d;
    end
  end

  // Write port: one-cycle registered copy of each accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= beat;
      if (beat) begin
        wr_addr_q <= BASE_ADDR + 32'(cnt_q);
        wr_data_q <= s_data;
      end
    end
  end

  // Region decode for debug visibility
  always_comb begin
    region = 2'd3;
    if (state_q == StLoad) begin
      if (cnt_q < KernelEnd)    region = 2'd0;
      else if (cnt_q < BiasEnd) region = 2'd1;
      else                      region = 2'd2;
    end
  end

  assign weight_wr_en   = wr_en_q;
  assign weight_wr_addr = wr_addr_q;
  assign weight_wr_data = wr_data_q;
  assign busy           = (state_q == StLoad);
  assign load_done      = load_done_q;
  assign act_valid_out  = act_valid_in & load_done_q;
  assign act_rd_en_out  = act_rd_en_in & load_done_q;

endmodule

// File: tb/tb_conv_weight_load_ctrl.sv
// Self-checking bench for conv_weight_load_ctrl: random and directed loads
// compared every cycle against a transaction-level model, plus literal pins.
module tb_conv_weight_load_ctrl;

  localparam int TOTAL = 77;
`ifdef CONV_WEIGHT_LOAD_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk, rst, start, abort, s_valid, act_valid_in, act_rd_en_in;
  logic [31:0] s_data, exp_sum;
  logic        s_ready, weight_wr_en, act_valid_out, act_rd_en_out, busy, load_done;
  logic [31:0] weight_wr_data, weight_wr_addr;
  logic [1:0]  region;
`ifdef CONV_WEIGHT_LOAD_CHECKSUM_EN
  logic        sum_err;
`endif

  conv_weight_load_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .weight_wr_data(weight_wr_data), .weight_wr_addr(weight_wr_addr),
    .weight_wr_en(weight_wr_en),
    .act_valid_in(act_valid_in), .act_valid_out(act_valid_out),
    .act_rd_en_in(act_rd_en_in), .act_rd_en_out(act_rd_en_out),
    .busy(busy), .load_done(load_done),
`ifdef CONV_WEIGHT_LOAD_CHECKSUM_EN
    .exp_sum(exp_sum), .sum_err(sum_err),
`endif
    .region(region)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int act_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_phase;   // 0 idle, 1 loading, 2 done
  int          m_cnt;     // words accepted in the current load
  logic        m_wr_en, m_done, m_pend, m_sum_err;
  logic [31:0] m_wr_addr, m_wr_data, m_sum;
  logic        m_beat;
  assign m_beat = (m_phase == 1) && s_valid && !abort;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_cnt <= 0; m_wr_en <= 0; m_wr_addr <= 0; m_wr_data <= 0;
      m_done <= 0; m_pend <= 0; m_sum <= 0; m_sum_err <= 0;
    end else begin
      m_wr_en <= m_beat;
      if (m_beat) begin
        m_wr_addr <= 32'(m_cnt);
        m_wr_data <= s_data;
      end
      if (abort || (start && m_phase != 1)) begin
        m_phase <= abort ? 0 : 1;
        m_cnt <= 0; m_done <= 0; m_pend <= 0; m_sum <= 0; m_sum_err <= 0;
      end else begin
        if (m_beat) begin
          m_cnt <= m_cnt + 1;
          m_sum <= m_sum + s_data;
          if (m_cnt == TOTAL - 1) begin
            m_phase   <= 2;
            m_pend    <= 1;
            m_sum_err <= CK && ((m_sum + s_data) != exp_sum);
          end
        end
        if (m_pend) begin
          m_pend <= 0;
          m_done <= !m_sum_err;
        end
      end
    end
  end

  function automatic logic [1:0] region_of(input int phase, input int cnt);
    if (phase != 1) return 2'd3;
    if (cnt < 72) return 2'd0;
    if (cnt < 76) return 2'd1;
    return 2'd2;
  endfunction

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("s_ready", s_ready, m_phase == 1);
    chk("busy", busy, m_phase == 1);
    chk("region", region, region_of(m_phase, m_cnt));
    chk("wr_en", weight_wr_en, m_wr_en);
    chk("load_done", load_done, m_done);
    chk("act_valid_out", act_valid_out, act_valid_in & m_done);
    chk("act_rd_en_out", act_rd_en_out, act_rd_en_in & m_done);
    if (m_wr_en) begin
      chk("wr_addr", weight_wr_addr, m_wr_addr);
      chk("wr_data", weight_wr_data, m_wr_data);
    end
`ifdef CONV_WEIGHT_LOAD_CHECKSUM_EN
    chk("sum_err", sum_err, m_sum_err);
`endif
  end

  // ---------------- observation for literal pins ----------------
  int          wr_cnt, last_wr_cyc, done_cyc;
  bit          done_seen;
  logic [31:0] first_addr, last_addr, last_data;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (weight_wr_en) begin
      if (wr_cnt == 0) first_addr = weight_wr_addr;
      wr_cnt++;
      last_wr_cyc = cyc;
      last_addr   = weight_wr_addr;
      last_data   = weight_wr_data;
    end
    if (load_done && !done_seen) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
  end

  task automatic clear_mon();
    wr_cnt = 0; done_seen = 0; last_wr_cyc = 0; done_cyc = 0;
  endtask

  // Activation inputs: held high (mode 0) or randomised (mode 1)
  initial begin
    act_valid_in = 1'b1;
    act_rd_en_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      act_valid_in = (act_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      act_rd_en_in = (act_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wr_en", weight_wr_en, 0);
    chk("rst_wr_addr", weight_wr_addr, 0);
    chk("rst_wr_data", weight_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_region", region, 3);
    chk("rst_act_valid_out", act_valid_out, 0);
    chk("rst_act_rd_en_out", act_rd_en_out, 0);
  endtask

  // One load: pat 0 back-to-back, 1 alternating 1010.., 2 random valid with
  // stray start pulses. kill_at >= 0 aborts (or resets) once that many words
  // have been accepted.
  task automatic run_load(input int pat, input int kill_at, input bit kill_rst,
                          input logic [31:0] off, input bit bad, input bit pin);
    int idx;
    int guard;
    bit acc;
    bit killed;
    idx = 0; guard = 0; killed = 0;
    exp_sum = off * 32'd77 + 32'd2926 + (bad ? 32'd1 : 32'd0);
    start = 1; s_valid = 0;
    tick();
    start = 0;
    while (idx < TOTAL && guard < 2000 && !killed) begin
      case (pat)
        0:       s_valid = 1'b1;
        1:       s_valid = (guard % 2 == 0);
        default: s_valid = ($urandom_range(0, 2) != 0);
      endcase
      s_data = off + 32'(idx);
      if (pat == 2) start = ($urandom_range(0, 15) == 0);
      if (idx == kill_at && kill_rst) begin
        #1;
        rst = 1'b1;
        #1;
        chk_reset_vals();
        s_valid = 0; start = 0;
        tick();
        tick();
        rst = 1'b0;
        killed = 1;
      end else begin
        if (idx == kill_at) abort = 1'b1;
        #3;
        acc = s_valid && s_ready;
        if (pin && acc) begin
          if (idx == 0 || idx == 71) chk("region_kernel", region, 0);
          else if (idx == 72 || idx == 75) chk("region_bias", region, 1);
          else if (idx == 76) chk("region_macc", region, 2);
        end
        tick();
        start = 0;
        if (abort) begin
          abort = 0; s_valid = 0; killed = 1;
        end
        if (acc) idx++;
        guard++;
      end
    end
    s_valid = 0; start = 0;
    if (kill_at < 0) chk("load_timeout", idx, TOTAL);
    if (!killed) repeat (3) tick();
  endtask

  initial begin
    int snap;
    rst = 1'b1; start = 0; abort = 0; s_valid = 0; s_data = 0; exp_sum = 0;
    clear_mon();
    @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;
    tick();
    chk("idle_act_gated", act_valid_out, 0);

    // Back-to-back load with literal pins
    clear_mon();
    run_load(0, -1, 0, 32'h100, 0, 1);
    chk("wr_count", wr_cnt, 77);
    chk("first_addr", first_addr, 0);
    chk("last_addr", last_addr, 76);
    chk("last_data", last_data, 32'h14c);
    chk("done_latency", done_cyc - last_wr_cyc, 1);
    chk("done_level", load_done, 1);
    chk("act_follows", act_valid_out, 1);

    // Alternating source valid
    clear_mon();
    run_load(1, -1, 0, 32'h100, 0, 1);
    chk("toggle_wr_count", wr_cnt, 77);
    chk("toggle_last_addr", last_addr, 76);

    // Abort after word 40, then full reload
    run_load(0, 41, 0, 32'h100, 0, 0);
    #2;
    chk("abort_s_ready", s_ready, 0);
    chk("abort_done", load_done, 0);
    snap = wr_cnt;
    repeat (5) tick();
    chk("abort_no_writes", wr_cnt, snap);
    clear_mon();
    run_load(0, -1, 0, 32'h100, 0, 0);
    chk("reload_count", wr_cnt, 77);
    chk("reload_first_addr", first_addr, 0);

    // Asynchronous reset at word 20, then load again
    run_load(0, 20, 1, 32'h100, 0, 0);
    clear_mon();
    run_load(0, -1, 0, 32'h200, 0, 0);
    chk("post_rst_count", wr_cnt, 77);
    chk("post_rst_done", load_done, 1);

    // start and abort together in IDLE stays IDLE
    abort = 1; tick(); abort = 0;
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    #2;
    chk("start_abort_idle", busy, 0);
    tick();

`ifdef CONV_WEIGHT_LOAD_CHECKSUM_EN
    run_load(0, -1, 0, 32'h100, 1, 0);
    chk("cs_bad_err", sum_err, 1);
    chk("cs_bad_done", load_done, 0);
    run_load(0, -1, 0, 32'h100, 0, 0);
    chk("cs_ok_err", sum_err, 0);
    chk("cs_ok_done", load_done, 1);
`endif

    // Randomised loads with random activation traffic
    act_mode = 1;
    for (int k = 0; k < 8; k++) begin
      run_load($urandom_range(0, 2),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 76)) : -1,
               0, $urandom, 1'($urandom_range(0, 1)), 0);
      repeat (2) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
